// File: rtl/tl45_decode.sv
// tl45 decode / register-read stage: field split, operand forwarding, target math,
// load-use interlock, HALT. Define TL45_ILLEGAL_TRAP_EN to trap opcodes 10-15.
module tl45_decode (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_pipe_stall,
   input  logic        i_pipe_flush,
   output logic        o_pipe_stall,
   output logic        o_pipe_flush,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_instr,
   output logic [3:0]  o_rf_sr1,
   output logic [3:0]  o_rf_sr2,
   input  logic [31:0] i_rf_sr1_val,
   input  logic [31:0] i_rf_sr2_val,
   input  logic [3:0]  i_of1_reg,
   input  logic [31:0] i_of1_val,
   input  logic [3:0]  i_of2_reg,
   input  logic [31:0] i_of2_val,
   output logic [31:0] o_pc,
   output logic [3:0]  o_opcode,
   output logic [3:0]  o_dr,
   output logic        o_skp_mode,
   output logic [31:0] o_sr1_val,
   output logic [31:0] o_sr2_val,
   output logic [31:0] o_target_address,
   output logic        o_halted,
   output logic        o_illegal
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_NAND = 4'd1;
   localparam logic [3:0] OP_ADDI = 4'd2;
   localparam logic [3:0] OP_LW   = 4'd3;
   localparam logic [3:0] OP_SW   = 4'd4;
   localparam logic [3:0] OP_GOTO = 4'd5;
   localparam logic [3:0] OP_JALR = 4'd6;
   localparam logic [3:0] OP_HALT = 4'd7;
   localparam logic [3:0] OP_SKP  = 4'd8;
   localparam logic [3:0] OP_LEA  = 4'd9;

   logic [3:0]  op, rx, ry, rz;
   logic [31:0] off;

   assign op  = i_instr[31:28];
   assign rx  = i_instr[27:24];
   assign ry  = i_instr[23:20];
   assign rz  = i_instr[3:0];
   assign off = {{12{i_instr[19]}}, i_instr[19:0]};

   logic [3:0]  sel_a, sel_b;
   logic [31:0] fwd_a, fwd_b;
   logic [3:0]  dec_opcode, dec_dr;
   logic        dec_skp, dec_halt;
   logic [31:0] dec_pc, dec_sr1, dec_sr2, dec_target;
`ifdef TL45_ILLEGAL_TRAP_EN
   logic        dec_illegal;
`endif
   logic        load_use;

   // Source selection first, so the forwarded operands are ready for the payload case.
   always_comb begin
      sel_a      = 4'd0;
      sel_b      = 4'd0;
      dec_opcode = 4'd0;
      dec_dr     = 4'd0;
      dec_skp    = 1'b0;
      dec_halt   = 1'b0;
      dec_pc     = 32'd0;
      dec_sr1    = 32'd0;
      dec_sr2    = 32'd0;
      dec_target = 32'd0;
`ifdef TL45_ILLEGAL_TRAP_EN
      dec_illegal = 1'b0;
`endif
      case (op)
         OP_ADD, OP_NAND: begin sel_a = ry; sel_b = rz; end
         OP_ADDI:         sel_a = ry;
         OP_LW:           sel_b = ry;
         OP_SW, OP_SKP:   begin sel_a = rx; sel_b = ry; end
         OP_JALR:         sel_a = rx;
         default: ;
      endcase

      // ALU-stage result is newer than the memory-stage one, so of1 wins.
      if (sel_a == 4'd0)            fwd_a = 32'd0;
      else if (sel_a == i_of1_reg)  fwd_a = i_of1_val;
      else if (sel_a == i_of2_reg)  fwd_a = i_of2_val;
      else                          fwd_a = i_rf_sr1_val;

      if (sel_b == 4'd0)            fwd_b = 32'd0;
      else if (sel_b == i_of1_reg)  fwd_b = i_of1_val;
      else if (sel_b == i_of2_reg)  fwd_b = i_of2_val;
      else                          fwd_b = i_rf_sr2_val;

      case (op)
         OP_ADD, OP_NAND: begin
            dec_opcode = op; dec_pc = i_pc; dec_dr = rx;
            dec_sr1 = fwd_a; dec_sr2 = fwd_b;
         end
         OP_ADDI: begin
            dec_opcode = op; dec_pc = i_pc; dec_dr = rx;
            dec_sr1 = fwd_a; dec_sr2 = off;
         end
         OP_LW: begin
            dec_opcode = op; dec_pc = i_pc; dec_dr = rx;
            dec_target = fwd_b + off;
         end
         OP_SW: begin
            dec_opcode = op; dec_pc = i_pc;
            dec_sr1 = fwd_a; dec_target = fwd_b + off;
         end
         OP_GOTO: begin
            dec_opcode = op; dec_pc = i_pc;
            dec_target = i_pc + 32'd1 + off;
         end
         OP_JALR: begin
            dec_opcode = op; dec_pc = i_pc; dec_dr = ry; dec_sr1 = fwd_a;
         end
         OP_HALT: dec_halt = 1'b1;
         OP_SKP: begin
            dec_opcode = op; dec_pc = i_pc; dec_skp = i_instr[0];
            dec_sr1 = fwd_a; dec_sr2 = fwd_b; dec_target = i_pc + 32'd2;
         end
         OP_LEA: begin
            dec_opcode = op; dec_pc = i_pc; dec_dr = rx;
            dec_target = i_pc + 32'd1 + off;
         end
         default: begin
`ifdef TL45_ILLEGAL_TRAP_EN
            dec_illegal = 1'b1;
`endif
         end
      endcase
   end

   // Unused source selects are 0 and o_dr is nonzero here, so they never match.
   assign load_use = (o_opcode == OP_LW) && (o_dr != 4'd0) &&
                     ((sel_a == o_dr) || (sel_b == o_dr));

   assign o_rf_sr1     = sel_a;
   assign o_rf_sr2     = sel_b;
   assign o_pipe_stall = i_pipe_stall | load_use | o_halted;
   assign o_pipe_flush = i_pipe_flush;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_pipe_flush || (!i_pipe_stall && (load_use || o_halted))) begin
         o_pc             <= 32'd0;
         o_opcode         <= 4'd0;
         o_dr             <= 4'd0;
         o_skp_mode       <= 1'b0;
         o_sr1_val        <= 32'd0;
         o_sr2_val        <= 32'd0;
         o_target_address <= 32'd0;
      end else if (!i_pipe_stall) begin
         o_pc             <= dec_pc;
         o_opcode         <= dec_opcode;
         o_dr             <= dec_dr;
         o_skp_mode       <= dec_skp;
         o_sr1_val        <= dec_sr1;
         o_sr2_val        <= dec_sr2;
         o_target_address <= dec_target;
      end
   end

   // Sticky status only latches when the instruction actually enters the buffer.
`ifdef TL45_ILLEGAL_TRAP_EN
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_halted  <= 1'b0;
         o_illegal <= 1'b0;
      end else if (!i_pipe_flush && !i_pipe_stall && !load_use && !o_halted) begin
         if (dec_halt || dec_illegal) o_halted <= 1'b1;
         if (dec_illegal)             o_illegal <= 1'b1;
      end
   end
`else
   always_ff @(posedge i_clk) begin
      if (i_reset)
         o_halted <= 1'b0;
      else if (!i_pipe_flush && !i_pipe_stall && !load_use && !o_halted && dec_halt)
         o_halted <= 1'b1;
   end

   assign o_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_tl45_decode.sv
// Directed-vector bench for tl45_decode; covers both TL45_ILLEGAL_TRAP_EN builds.
module tb_tl45_decode;

   logic        i_clk = 1'b0;
   logic        i_reset, i_pipe_stall, i_pipe_flush;
   logic        o_pipe_stall, o_pipe_flush;
   logic [31:0] i_pc, i_instr;
   logic [3:0]  o_rf_sr1, o_rf_sr2;
   logic [31:0] i_rf_sr1_val, i_rf_sr2_val;
   logic [3:0]  i_of1_reg, i_of2_reg;
   logic [31:0] i_of1_val, i_of2_val;
   logic [31:0] o_pc, o_sr1_val, o_sr2_val, o_target_address;
   logic [3:0]  o_opcode, o_dr;
   logic        o_skp_mode, o_halted, o_illegal;

   logic [31:0] rf [16];
   int          nvec = 0;
   int          nerr = 0;

   always #5 i_clk = ~i_clk;

   assign i_rf_sr1_val = rf[o_rf_sr1];
   assign i_rf_sr2_val = rf[o_rf_sr2];

   tl45_decode dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_pipe_stall(i_pipe_stall), .i_pipe_flush(i_pipe_flush),
      .o_pipe_stall(o_pipe_stall), .o_pipe_flush(o_pipe_flush),
      .i_pc(i_pc), .i_instr(i_instr),
      .o_rf_sr1(o_rf_sr1), .o_rf_sr2(o_rf_sr2),
      .i_rf_sr1_val(i_rf_sr1_val), .i_rf_sr2_val(i_rf_sr2_val),
      .i_of1_reg(i_of1_reg), .i_of1_val(i_of1_val),
      .i_of2_reg(i_of2_reg), .i_of2_val(i_of2_val),
      .o_pc(o_pc), .o_opcode(o_opcode), .o_dr(o_dr), .o_skp_mode(o_skp_mode),
      .o_sr1_val(o_sr1_val), .o_sr2_val(o_sr2_val),
      .o_target_address(o_target_address),
      .o_halted(o_halted), .o_illegal(o_illegal)
   );

   function automatic logic [31:0] r_type(input logic [3:0] op, input logic [3:0] rx,
                                          input logic [3:0] ry, input logic [3:0] rz);
      return {op, rx, ry, 16'h0000, rz};
   endfunction

   function automatic logic [31:0] i_type(input logic [3:0] op, input logic [3:0] rx,
                                          input logic [3:0] ry, input logic [19:0] imm);
      return {op, rx, ry, imm};
   endfunction

   // Inputs change 1ns after the edge; registered outputs are read at the same point.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      i_reset = 1'b1; i_pipe_stall = 1'b0; i_pipe_flush = 1'b0;
      i_of1_reg = 4'd0; i_of1_val = 32'h0; i_of2_reg = 4'd0; i_of2_val = 32'h0;
      i_pc = 32'h100; i_instr = r_type(4'd0, 4'd3, 4'd1, 4'd2);
      step(); step();
      nvec++; if (o_opcode !== 4'd0) begin nerr++; $display("[TB] FAIL rst_opcode got %h want 0", o_opcode); end
      nvec++; if (o_dr !== 4'd0) begin nerr++; $display("[TB] FAIL rst_dr got %h want 0", o_dr); end
      nvec++; if (o_sr1_val !== 32'd0) begin nerr++; $display("[TB] FAIL rst_sr1 got %h want 0", o_sr1_val); end
      nvec++; if (o_pc !== 32'd0) begin nerr++; $display("[TB] FAIL rst_pc got %h want 0", o_pc); end
      nvec++; if (o_halted !== 1'b0) begin nerr++; $display("[TB] FAIL rst_halted got %b want 0", o_halted); end
      nvec++; if (o_pipe_stall !== 1'b0) begin nerr++; $display("[TB] FAIL rst_stall got %b want 0", o_pipe_stall); end
      i_reset = 1'b0;
   endtask

   task automatic test_add();
      i_pc = 32'h100; i_instr = r_type(4'd0, 4'd3, 4'd1, 4'd2);
      #1;
      nvec++; if (o_rf_sr1 !== 4'd1) begin nerr++; $display("[TB] FAIL add_rfsr1 got %h want 1", o_rf_sr1); end
      nvec++; if (o_rf_sr2 !== 4'd2) begin nerr++; $display("[TB] FAIL add_rfsr2 got %h want 2", o_rf_sr2); end
      step();
      nvec++; if (o_opcode !== 4'd0) begin nerr++; $display("[TB] FAIL add_opcode got %h want 0", o_opcode); end
      nvec++; if (o_dr !== 4'd3) begin nerr++; $display("[TB] FAIL add_dr got %h want 3", o_dr); end
      nvec++; if (o_sr1_val !== 32'd5) begin nerr++; $display("[TB] FAIL add_sr1 got %h want 5", o_sr1_val); end
      nvec++; if (o_sr2_val !== 32'd7) begin nerr++; $display("[TB] FAIL add_sr2 got %h want 7", o_sr2_val); end
      nvec++; if (o_pc !== 32'h100) begin nerr++; $display("[TB] FAIL add_pc got %h want 100", o_pc); end
      i_pc = 32'h104; i_instr = r_type(4'd1, 4'd8, 4'd5, 4'd6);
      step();
      nvec++; if (o_opcode !== 4'd1) begin nerr++; $display("[TB] FAIL nand_opcode got %h want 1", o_opcode); end
      nvec++; if (o_sr1_val !== 32'h105 || o_sr2_val !== 32'h106) begin nerr++; $display("[TB] FAIL nand_ops got %h/%h want 105/106", o_sr1_val, o_sr2_val); end
   endtask

   task automatic test_forward();
      i_of1_reg = 4'd3; i_of1_val = 32'd12; i_of2_reg = 4'd3; i_of2_val = 32'd99;
      i_pc = 32'h108; i_instr = i_type(4'd2, 4'd4, 4'd3, 20'hFFFFF);
      step();
      nvec++; if (o_sr1_val !== 32'd12) begin nerr++; $display("[TB] FAIL fwd_of1 got %h want c", o_sr1_val); end
      nvec++; if (o_sr2_val !== 32'hFFFFFFFF) begin nerr++; $display("[TB] FAIL addi_imm got %h want ffffffff", o_sr2_val); end
      nvec++; if (o_dr !== 4'd4 || o_opcode !== 4'd2) begin nerr++; $display("[TB] FAIL addi_dr_op got %h/%h want 4/2", o_dr, o_opcode); end
      i_of1_reg = 4'd0; i_of1_val = 32'h55;
      i_instr = r_type(4'd0, 4'd6, 4'd0, 4'd3);
      step();
      nvec++; if (o_sr1_val !== 32'd0) begin nerr++; $display("[TB] FAIL r0_zero got %h want 0", o_sr1_val); end
      nvec++; if (o_sr2_val !== 32'd99) begin nerr++; $display("[TB] FAIL fwd_of2 got %h want 63", o_sr2_val); end
      i_of2_reg = 4'd0; i_of2_val = 32'h0; i_of1_val = 32'h0;
   endtask

   task automatic test_load_use();
      i_pc = 32'h200; i_instr = i_type(4'd3, 4'd2, 4'd1, 20'd4);
      step();
      nvec++; if (o_opcode !== 4'd3 || o_dr !== 4'd2) begin nerr++; $display("[TB] FAIL lw_op_dr got %h/%h want 3/2", o_opcode, o_dr); end
      nvec++; if (o_target_address !== 32'd9) begin nerr++; $display("[TB] FAIL lw_target got %h want 9", o_target_address); end
      i_pc = 32'h201; i_instr = r_type(4'd0, 4'd5, 4'd2, 4'd2);
      #1;
      nvec++; if (o_pipe_stall !== 1'b1) begin nerr++; $display("[TB] FAIL lu_stall got %b want 1", o_pipe_stall); end
      step();
      nvec++; if (o_dr !== 4'd0 || o_pc !== 32'd0) begin nerr++; $display("[TB] FAIL lu_bubble got dr %h pc %h want 0/0", o_dr, o_pc); end
      i_of2_reg = 4'd2; i_of2_val = 32'h40;
      #1;
      nvec++; if (o_pipe_stall !== 1'b0) begin nerr++; $display("[TB] FAIL lu_release got %b want 0", o_pipe_stall); end
      step();
      nvec++; if (o_dr !== 4'd5) begin nerr++; $display("[TB] FAIL lu_dr got %h want 5", o_dr); end
      nvec++; if (o_sr1_val !== 32'h40 || o_sr2_val !== 32'h40) begin nerr++; $display("[TB] FAIL lu_ops got %h/%h want 40/40", o_sr1_val, o_sr2_val); end
      i_of2_reg = 4'd0; i_of2_val = 32'h0;
   endtask

   task automatic test_stall_flush();
      i_pc = 32'h300; i_instr = i_type(4'd2, 4'd4, 4'd3, 20'd1);
      i_pipe_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         nvec++; if (o_dr !== 4'd5 || o_sr1_val !== 32'h40) begin nerr++; $display("[TB] FAIL stall_hold%0d got dr %h sr1 %h want 5/40", k, o_dr, o_sr1_val); end
         nvec++; if (o_pipe_stall !== 1'b1) begin nerr++; $display("[TB] FAIL stall_out%0d got %b want 1", k, o_pipe_stall); end
      end
      i_pipe_flush = 1'b1;
      #1;
      nvec++; if (o_pipe_flush !== 1'b1) begin nerr++; $display("[TB] FAIL flush_pass got %b want 1", o_pipe_flush); end
      step();
      nvec++; if (o_dr !== 4'd0 || o_sr1_val !== 32'd0 || o_pc !== 32'd0) begin nerr++; $display("[TB] FAIL flush_clear got dr %h sr1 %h pc %h want 0", o_dr, o_sr1_val, o_pc); end
      i_pipe_flush = 1'b0; i_pipe_stall = 1'b0;
   endtask

   task automatic test_targets();
      i_pc = 32'h10; i_instr = i_type(4'd5, 4'd0, 4'd0, 20'hFFFFD);
      step();
      nvec++; if (o_target_address !== 32'h0E || o_opcode !== 4'd5) begin nerr++; $display("[TB] FAIL goto got %h op %h want e/5", o_target_address, o_opcode); end
      i_pc = 32'h20; i_instr = i_type(4'd8, 4'd1, 4'd2, 20'd1);
      step();
      nvec++; if (o_target_address !== 32'h22) begin nerr++; $display("[TB] FAIL skp_target got %h want 22", o_target_address); end
      nvec++; if (o_skp_mode !== 1'b1 || o_sr1_val !== 32'd5 || o_sr2_val !== 32'd7) begin nerr++; $display("[TB] FAIL skp_fields got %b %h %h want 1 5 7", o_skp_mode, o_sr1_val, o_sr2_val); end
      i_pc = 32'h24; i_instr = i_type(4'd4, 4'd1, 4'd2, 20'd8);
      step();
      nvec++; if (o_target_address !== 32'd15 || o_sr1_val !== 32'd5 || o_dr !== 4'd0) begin nerr++; $display("[TB] FAIL sw got %h %h %h want f 5 0", o_target_address, o_sr1_val, o_dr); end
      i_pc = 32'h30; i_instr = i_type(4'd9, 4'd9, 4'd0, 20'h10);
      step();
      nvec++; if (o_target_address !== 32'h41 || o_dr !== 4'd9) begin nerr++; $display("[TB] FAIL lea got %h %h want 41 9", o_target_address, o_dr); end
      i_pc = 32'h50; i_instr = r_type(4'd6, 4'd1, 4'd14, 4'd0);
      step();
      nvec++; if (o_dr !== 4'd14 || o_sr1_val !== 32'd5 || o_pc !== 32'h50) begin nerr++; $display("[TB] FAIL jalr got %h %h %h want e 5 50", o_dr, o_sr1_val, o_pc); end
      i_pc = 32'hFFFFFFFF; i_instr = i_type(4'd5, 4'd0, 4'd0, 20'd0);
      step();
      nvec++; if (o_target_address !== 32'd0) begin nerr++; $display("[TB] FAIL goto_wrap got %h want 0", o_target_address); end
   endtask

   task automatic test_halt();
      i_pc = 32'h400; i_instr = r_type(4'd7, 4'd0, 4'd0, 4'd0); i_pipe_flush = 1'b1;
      step();
      nvec++; if (o_halted !== 1'b0) begin nerr++; $display("[TB] FAIL halt_flushed got %b want 0", o_halted); end
      i_pipe_flush = 1'b0; i_instr = r_type(4'd0, 4'd3, 4'd1, 4'd2);
      step();
      i_instr = r_type(4'd7, 4'd0, 4'd0, 4'd0);
      step();
      nvec++; if (o_halted !== 1'b1) begin nerr++; $display("[TB] FAIL halt_set got %b want 1", o_halted); end
      nvec++; if (o_dr !== 4'd0 || o_pc !== 32'd0 || o_opcode !== 4'd0) begin nerr++; $display("[TB] FAIL halt_bubble got dr %h pc %h op %h want 0", o_dr, o_pc, o_opcode); end
      i_instr = r_type(4'd0, 4'd3, 4'd1, 4'd2);
      step(); step();
      nvec++; if (o_pipe_stall !== 1'b1 || o_dr !== 4'd0) begin nerr++; $display("[TB] FAIL halt_hold got stall %b dr %h want 1/0", o_pipe_stall, o_dr); end
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      nvec++; if (o_halted !== 1'b0 || o_pipe_stall !== 1'b0) begin nerr++; $display("[TB] FAIL halt_reset got %b/%b want 0/0", o_halted, o_pipe_stall); end
   endtask

   task automatic test_reset_mid_stall();
      i_pc = 32'h500; i_instr = i_type(4'd3, 4'd2, 4'd1, 20'd4);
      step();
      i_instr = r_type(4'd0, 4'd5, 4'd2, 4'd2); i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      nvec++; if (o_opcode !== 4'd0 || o_dr !== 4'd0 || o_pipe_stall !== 1'b0) begin nerr++; $display("[TB] FAIL rst_mid got op %h dr %h stall %b want 0", o_opcode, o_dr, o_pipe_stall); end
   endtask

   task automatic test_illegal();
      i_pc = 32'h600; i_instr = 32'hC3120000; i_pipe_flush = 1'b1;
      step();
      i_pipe_flush = 1'b0;
      nvec++; if (o_illegal !== 1'b0 || o_halted !== 1'b0) begin nerr++; $display("[TB] FAIL ill_flushed got %b/%b want 0/0", o_illegal, o_halted); end
      step();
      nvec++; if (o_opcode !== 4'd0 || o_dr !== 4'd0 || o_pc !== 32'd0) begin nerr++; $display("[TB] FAIL ill_bubble got op %h dr %h pc %h want 0", o_opcode, o_dr, o_pc); end
`ifdef TL45_ILLEGAL_TRAP_EN
      nvec++; if (o_illegal !== 1'b1 || o_halted !== 1'b1) begin nerr++; $display("[TB] FAIL ill_trap got %b/%b want 1/1", o_illegal, o_halted); end
`else
      nvec++; if (o_illegal !== 1'b0 || o_halted !== 1'b0) begin nerr++; $display("[TB] FAIL ill_notrap got %b/%b want 0/0", o_illegal, o_halted); end
`endif
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 16; k++) rf[k] = 32'h100 + k;
      rf[0] = 32'd0; rf[1] = 32'd5; rf[2] = 32'd7;
      test_reset();
      test_add();
      test_forward();
      test_load_use();
      test_stall_flush();
      test_targets();
      test_halt();
      test_reset_mid_stall();
      test_illegal();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/tl45_decode.md
Name: tl45_decode

Overview:
- Decode/register-read stage of the tl45 core. Sits between fetch and the ALU stage.
- Splits a 32-bit instruction into fields and reads operands from the combinational register file.
- Resolves operands through the ALU and memory forward paths and computes target addresses.
- Drives the registered ALU-stage input buffer. Handles stall, flush, load-use hazards and HALT.

Parameters:
- none (data 32 bits, register index 4 bits, fixed by ISA)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_pipe_stall  in  1  ALU stage stalled; hold buffer
- i_pipe_flush  in  1  ALU stage flush (taken jump); clear buffer
- o_pipe_stall  out  1  stall fetch
- o_pipe_flush  out  1  flush fetch
- i_pc  in  32  PC of i_instr
- i_instr  in  32  instruction from fetch; all-zero = NOP
- o_rf_sr1, o_rf_sr2  out  4  register file read addresses
- i_rf_sr1_val, i_rf_sr2_val  in  32  register file read data, same cycle
- i_of1_reg, i_of1_val  in  4/32  ALU-stage forward; reg 0 = none
- i_of2_reg, i_of2_val  in  4/32  memory-stage forward; reg 0 = none
- o_pc  out  32  buffered PC
- o_opcode  out  4  buffered opcode
- o_dr  out  4  buffered destination register
- o_skp_mode  out  1  buffered SKP mode: 0 = EQ, 1 = LT
- o_sr1_val, o_sr2_val  out  32  buffered operands
- o_target_address  out  32  buffered target or effective address
- o_halted  out  1  sticky HALT state
- o_illegal  out  1  sticky illegal-opcode flag

Behaviour:
- Fields: op = [31:28], RX = [27:24], RY = [23:20], RZ = [3:0], off = sext([19:0]), skp_mode = [0].
- Operand forwarding, per source register r:
  - r = 0 → 0.
  - else r == i_of1_reg → i_of1_val.
  - else r == i_of2_reg → i_of2_val.
  - else register file value.
  - of1 has priority over of2.
- Per-opcode decode (A → o_rf_sr1, B → o_rf_sr2; unused addresses = 0; unlisted outputs = 0):
  - ADD 0 / NAND 1: dr = RX, A = RY, B = RZ; sr1 = fwd A, sr2 = fwd B.
  - ADDI 2: dr = RX, A = RY; sr1 = fwd A, sr2 = off.
  - LW 3: dr = RX, B = RY; target = fwd B + off.
  - SW 4: dr = 0, A = RX, B = RY; sr1 = fwd A; target = fwd B + off.
  - GOTO 5: target = pc + 1 + off.
  - JALR 6: dr = RY, A = RX; sr1 = fwd A.
  - HALT 7: buffer loads bubble; o_halted set.
  - SKP 8: A = RX, B = RY; sr1 = fwd A, sr2 = fwd B; skp_mode = instr[0]; target = pc + 2.
  - LEA 9: dr = RX; target = pc + 1 + off.
  - 10–15: bubble (see the optional feature).
- Address arithmetic is 32-bit and wraps modulo 2^32.
- Bubble = all buffered outputs 0 (ADD r0, r0, r0).
- Buffer update, one per cycle, priority order:
  1. i_reset: buffer = 0, o_halted = 0, o_illegal = 0.
  2. i_pipe_flush: buffer = 0. The instruction at the input is squashed and HALT is not latched.
  3. i_pipe_stall: buffer held unchanged.
  4. load-use: bubble loaded.
  5. o_halted: bubble loaded.
  6. otherwise the decoded instruction is loaded. Latency 1 cycle.
- Load-use hazard (combinational):
  - Condition: buffered o_opcode == LW, o_dr != 0, and the incoming instruction's used A or B equals o_dr.
  - Response: o_pipe_stall = 1 for one cycle and a bubble is loaded.
  - Next cycle the LW is in the memory stage and is resolved via of2.
- o_pipe_stall = i_pipe_stall | load_use | o_halted. Flush does not assert stall.
- o_pipe_flush = i_pipe_flush (pass-through).
- o_halted stays set until reset; fetch remains stalled.
- Reset mid-stall or mid-halt: all cleared the next cycle, no residue.

Optional Feature:
- Macro: TL45_ILLEGAL_TRAP_EN.
- Defined:
  - Opcode 10–15, when it would otherwise load, sets o_illegal and o_halted and loads a bubble.
  - A squashed (flushed) illegal opcode sets nothing.
- Undefined: opcodes 10–15 decode as a bubble, and o_illegal is tied to 0.

Test Plan:
- Reset, then i_instr = ADD r3, r1, r2 with regfile r1 = 5, r2 = 7 → next cycle o_opcode = 0, o_dr = 3, o_sr1_val = 5, o_sr2_val = 7; all outputs were 0 during reset.
- ADDI r4, r3, -1 with i_of1_reg = 3, i_of1_val = 12 and i_of2_reg = 3, i_of2_val = 99 → o_sr1_val = 12, o_sr2_val = 0xFFFFFFFF. Reading r0 always yields 0 even if i_of1_reg = 0.
- LW r2, 4(r1) followed by ADD r5, r2, r2 → one bubble cycle with o_pipe_stall = 1. Then, with i_of2_reg = 2, i_of2_val = 0x40, the ADD loads with sr1 = sr2 = 0x40.
- i_pipe_stall held 3 cycles → buffer unchanged and o_pipe_stall = 1. Assert i_pipe_flush together with i_pipe_stall → buffer cleared; o_pipe_flush = 1.
- GOTO off = -3 at pc = 0x10 → o_target_address = 0x0E. SKP mode 1 at pc = 0x20 → target = 0x22, o_skp_mode = 1.
- HALT with no flush → bubble, o_halted = 1, o_pipe_stall stays 1 until reset. HALT with i_pipe_flush = 1 → not halted. Under TL45_ILLEGAL_TRAP_EN, opcode 0xC → o_illegal = 1 and o_halted = 1.
